// File: rtl/stream_checker.sv
// Locks onto an address/LFSR-pattern walk and counts checked beats and mismatches; all outputs registered, updating at the accepting edge.
// in_ready is registered; with CHECKER_BACKPRESSURE_EN defined a throttle LFSR deasserts it pseudo-randomly.
module stream_checker #(
  parameter int DEPTH  = 625,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [3:0]        in_pattern,
  output logic              in_ready,
  output logic              locked,
  output logic [31:0]       beat_count,
  output logic [15:0]       err_count,
  output logic              err_pulse,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid
);

  typedef enum logic {HUNT, CHECK} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

  function automatic logic [3:0] next_pat(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction

  state_t              state_q, state_d;
  logic                accept, mismatch, load_exp, beat_inc;
  logic [ADDR_W-1:0]   exp_addr, nxt_addr;
  logic [3:0]          exp_pat;

  assign accept   = in_valid & in_ready;
  assign nxt_addr = (in_addr == LAST_ADDR) ? '0 : in_addr + 1'b1;
  assign locked   = (state_q == CHECK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // clear takes priority over any beat presented in the same cycle
  always_comb begin
    state_d  = state_q;
    mismatch = 1'b0;
    load_exp = 1'b0;
    beat_inc = 1'b0;
    if (clear) begin
      state_d = HUNT;
    end else if (accept) begin
      case (state_q)
        HUNT: begin
          if (in_pattern > 4'h1) begin
            state_d  = CHECK;
            load_exp = 1'b1;
          end
        end
        CHECK: begin
          load_exp = 1'b1;
          beat_inc = 1'b1;
          mismatch = (in_addr != exp_addr) || (in_pattern != exp_pat) ||
                     ({1'b0, in_addr} >= DEPTH_W);
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr        <= '0;
      exp_pat         <= '0;
      beat_count      <= '0;
      err_count       <= '0;
      err_pulse       <= 1'b0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else if (clear) begin
      beat_count      <= '0;
      err_count       <= '0;
      err_pulse       <= 1'b0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else begin
      err_pulse <= mismatch;
      // expectations always follow the received beat, so one bad beat costs at most two errors
      if (load_exp) begin
        exp_addr <= nxt_addr;
        exp_pat  <= next_pat(in_pattern);
      end
      if (beat_inc && (beat_count != '1))
        beat_count <= beat_count + 1'b1;
      if (mismatch) begin
        if (err_count != '1)
          err_count <= err_count + 1'b1;
        if (!first_err_valid) begin
          first_err_addr  <= in_addr;
          first_err_valid <= 1'b1;
        end
      end
    end
  end

`ifdef CHECKER_BACKPRESSURE_EN
  logic [3:0] throttle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      throttle <= 4'h5;
      in_ready <= 1'b0;
    end else begin
      throttle <= next_pat(throttle);
      in_ready <= (throttle[1:0] != 2'b00);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: a behavioural model checked every cycle plus literal expectations.
module tb_stream_checker;
  localparam int DEPTH = 625;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [3:0]    in_pattern = '0;
  logic          in_ready, locked, err_pulse, first_err_valid;
  logic [31:0]   beat_count;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  stream_checker #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_addr(in_addr), .in_pattern(in_pattern), .in_ready(in_ready),
    .locked(locked), .beat_count(beat_count), .err_count(err_count),
    .err_pulse(err_pulse), .first_err_addr(first_err_addr),
    .first_err_valid(first_err_valid)
  );

  function automatic int nxt(input int p);
    return ((p * 2) % 16) + (((p / 8) + (p / 4)) % 2);
  endfunction

  function automatic int wrap(input int a);
    if (a == DEPTH - 1) return 0;
    return (a + 1) % (1 << AW);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // behavioural model
  bit      m_rdy, m_lock, m_pulse, m_fev, m_acc, m_bad;
  int      m_thr, m_ea, m_ep, m_ec, m_fea;
  longint  m_bc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdy = 0; m_thr = 5; m_lock = 0; m_ea = 0; m_ep = 0;
      m_bc = 0; m_ec = 0; m_pulse = 0; m_fea = 0; m_fev = 0;
    end else begin
      m_acc = in_valid && m_rdy;
`ifdef CHECKER_BACKPRESSURE_EN
      m_rdy = (m_thr % 4) != 0;
      m_thr = nxt(m_thr);
`else
      m_rdy = 1;
`endif
      m_pulse = 0;
      if (clear) begin
        m_lock = 0; m_bc = 0; m_ec = 0; m_fea = 0; m_fev = 0;
      end else if (m_acc) begin
        if (!m_lock) begin
          if (int'(in_pattern) > 1) begin
            m_lock = 1;
            m_ea = wrap(int'(in_addr));
            m_ep = nxt(int'(in_pattern));
          end
        end else begin
          m_bad = (int'(in_addr) != m_ea) || (int'(in_pattern) != m_ep) ||
                  (int'(in_addr) >= DEPTH);
          if (m_bc < 64'hFFFF_FFFF) m_bc++;
          if (m_bad) begin
            m_pulse = 1;
            if (m_ec < 65535) m_ec++;
            if (!m_fev) begin m_fev = 1; m_fea = int'(in_addr); end
          end
          m_ea = wrap(int'(in_addr));
          m_ep = nxt(int'(in_pattern));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("locked", 32'(locked), 32'(m_lock));
      chk("beat_count", beat_count, 32'(m_bc));
      chk("err_count", 32'(err_count), 32'(m_ec));
      chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
      chk("first_err_addr", 32'(first_err_addr), 32'(m_fea));
      chk("first_err_valid", 32'(first_err_valid), 32'(m_fev));
    end
    if (err_pulse) pulses++;
  end

  // presents one beat, holds it until accepted, returns at the negedge after acceptance
  task automatic beat(input int a, input int p);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_addr = AW'(a);
    in_pattern = 4'(p);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout: in_ready stayed %0b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic clear_beat(input int a, input int p);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_addr = AW'(a); in_pattern = 4'(p);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0, acc, cur_a, cur_p;
    bit r;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    armed = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_beat_count", beat_count, 32'd0);
    #2 rst = 1'b0;
    #1 chk("first_cycle_in_ready", 32'(in_ready), 32'd0);

    // lock sequence: 0x1 ignored, 0xB locks
    beat(0, 4'h1);
    chk("hunt_ignores_1", 32'(locked), 32'd0);
    beat(1, 4'hB);
    chk("locked_after_B", 32'(locked), 32'd1);
    beat(2, 4'h7);
    beat(3, 4'hF);
    chk("lock_seq_beats", beat_count, 32'd2);
    chk("lock_seq_errs", 32'(err_count), 32'd0);

    // single corrupt pattern followed by a correct beat
    do_clear();
    beat(2, 4'h7);
    p0 = pulses;
    beat(3, 4'hE);
    chk("corrupt_fev", 32'(first_err_valid), 32'd1);
    chk("corrupt_fea", 32'(first_err_addr), 32'd3);
    beat(4, 4'hC);
    @(negedge clk);
    chk("corrupt_errs", 32'(err_count), 32'd1);
    chk("corrupt_pulses", 32'(pulses - p0), 32'd1);
    chk("corrupt_beats", beat_count, 32'd2);

    // address wrap at DEPTH-1, then out-of-range address
    do_clear();
    beat(623, 4'hB);
    beat(624, 4'h7);
    beat(0, 4'hF);
    chk("wrap_no_err", 32'(err_count), 32'd0);
    beat(625, 4'hE);
    chk("oob_pulse", 32'(err_pulse), 32'd1);
    chk("oob_errs", 32'(err_count), 32'd1);
    chk("oob_fea", 32'(first_err_addr), 32'd625);

    // clear coincident with a beat after five errors
    do_clear();
    beat(0, 4'hB);
    repeat (5) beat(10, 4'h5);
    chk("five_errs", 32'(err_count), 32'd5);
    chk("five_fea", 32'(first_err_addr), 32'd10);
    clear_beat(20, 4'h6);
    chk("clear_errs", 32'(err_count), 32'd0);
    chk("clear_beats", beat_count, 32'd0);
    chk("clear_locked", 32'(locked), 32'd0);
    chk("clear_fev", 32'(first_err_valid), 32'd0);
    beat(30, 4'hD);
    chk("relock_after_clear", 32'(locked), 32'd1);
    beat(31, 4'hA);
    beat(32, 4'h5);
    chk("relock_beats", beat_count, 32'd2);

    // mid-stream reset
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_beats", beat_count, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("midrst_release_ready", 32'(in_ready), 32'd0);
    beat(0, 4'h1);
    chk("midrst_ignore", 32'(locked), 32'd0);
    beat(7, 4'h9);
    chk("midrst_relock", 32'(locked), 32'd1);

    // continuous valid stream
    do_clear();
    cur_a = 100; cur_p = 5; acc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_addr = AW'(cur_a); in_pattern = 4'(cur_p);
    for (int i = 0; i < 30; i++) begin
      r = in_ready;
      @(negedge clk);
      if (r) begin
        acc++;
        cur_a = wrap(cur_a);
        cur_p = nxt(cur_p);
        in_addr = AW'(cur_a);
        in_pattern = 4'(cur_p);
      end
    end
    in_valid = 1'b0;
    chk("stream_beats", beat_count, 32'(acc - 1));
    chk("stream_errs", 32'(err_count), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
